// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Sequential instruction fetch front end. It issues one
//               word-aligned request at a time to instruction memory, buffers
//               returned words together with their fetch PC in a small FIFO,
//               and hands them to decode. A redirect flushes the buffer, loads
//               a new fetch PC, and discards any response still in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC        address of the first fetch after reset
//   DEPTH           fetched-instruction buffer entries (2 or 4)
// Ports
//   clock           single clock, rising edge
//   reset           asynchronous, active-high
//   mem_req_valid   fetch request to instruction memory
//   mem_req_addr    word-aligned fetch address (always the fetch PC)
//   mem_req_ready   memory accepts the request this cycle
//   mem_resp_valid  instruction word returned this cycle
//   mem_resp_data   returned instruction word
//   instr_valid     buffer head holds a valid instruction
//   instr_data      instruction word at the buffer head
//   instr_pc        fetch address of instr_data
//   instr_ready     decode consumes the head this cycle
//   redirect_valid  branch/jump redirect of the fetch stream
//   redirect_pc     new fetch address (bits [1:0] ignored)
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2   // waiting for a response that must be thrown away
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // PCs are kept as word addresses so the low two bits are zero by construction.
  logic [29:0] r_fetch_pc;
  logic [29:0] r_req_pc;

  logic [31:0]      r_buf_data [DEPTH];
  logic [29:0]      r_buf_pc   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_unused_redirect_lsbs;

  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  // Gated by reset so no request is visible while reset is held, even though
  // the state/count registers already read FETCH/empty.
  assign mem_req_valid = (r_state == ST_FETCH) && (r_count < c_depth_cnt) &&
                         !redirect_valid && !reset;
  assign mem_req_addr  = {r_fetch_pc, 2'b00};

  assign w_accept = mem_req_valid && mem_req_ready;
  assign w_push   = (r_state == ST_WAIT) && mem_resp_valid && !redirect_valid;
  assign w_pop    = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (r_count != '0);
  assign instr_data  = r_buf_data[r_head];
  assign instr_pc    = {r_buf_pc[r_head], 2'b00};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // A response in the redirect cycle is dropped; otherwise it is
          // still owed and must be drained before fetching again.
          w_state_nxt = mem_resp_valid ? ST_FETCH : ST_DRAIN;
        end else if (mem_resp_valid) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch PC and outstanding request PC
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC[31:2];
      r_req_pc   <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc[31:2];
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 30'd1;   // wraps modulo 2^32 bytes
      end
      if (w_accept) begin
        r_req_pc <= r_fetch_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetched-instruction buffer (circular, DEPTH is a power of two)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_tail] <= mem_resp_data;
        r_buf_pc[r_tail]   <= r_req_pc;
        r_tail             <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, entries in the fetched-instruction buffer; legal values are 2 and 4.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 mem_req_valid  output  1  fetch request to instruction memory.
REQ-006 mem_req_addr  output  32  word-aligned fetch address.
REQ-007 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 mem_resp_valid  input  1  instruction word returned this cycle.
REQ-009 mem_resp_data  input  32  returned instruction word.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction for decode.
REQ-011 instr_data  output  32  instruction word at the buffer head.
REQ-012 instr_pc  output  32  fetch address of instr_data.
REQ-013 instr_ready  input  1  decode consumes the head this cycle.
REQ-014 redirect_valid  input  1  branch/jump redirect of the fetch stream.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.

Function
REQ-016 The FSM SHALL have three states: FETCH, WAIT, and DRAIN (waiting on a response that must be discarded).
REQ-017 In FETCH, mem_req_valid SHALL be 1 only when buffer count < DEPTH and redirect_valid is 0; in WAIT and DRAIN it SHALL be 0.
REQ-018 mem_req_addr SHALL equal the fetch PC register at all times, with bits [1:0] always 0.
REQ-019 On mem_req_valid && mem_req_ready the fetch PC SHALL advance by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and the FSM SHALL go FETCH->WAIT, latching the request address as req_pc.
REQ-020 At most one request SHALL be outstanding; the response arrives no earlier than the cycle after acceptance.
REQ-021 In WAIT, when mem_resp_valid is 1, {req_pc, mem_resp_data} SHALL be pushed into the buffer and the FSM SHALL go to FETCH.
REQ-022 mem_resp_valid in FETCH SHALL be ignored.
REQ-023 A buffer entry SHALL be popped on instr_valid && instr_ready; pop and push in the same cycle SHALL leave count unchanged.
REQ-024 instr_valid SHALL equal (count != 0); instr_data and instr_pc SHALL come from registers (no combinational path from mem_resp_* to the outputs).
REQ-025 Redirect SHALL have priority over everything: the buffer is flushed, any same-cycle pop or push is cancelled, and the fetch PC is loaded with {redirect_pc[31:2],2'b00}.
REQ-026 On redirect in FETCH the FSM SHALL stay in FETCH.
REQ-027 On redirect in WAIT with mem_resp_valid=1, the response SHALL be discarded and the FSM SHALL go to FETCH.
REQ-028 On redirect in WAIT with mem_resp_valid=0, the FSM SHALL go to DRAIN.
REQ-029 On redirect in DRAIN, the FSM SHALL stay in DRAIN with the PC updated.
REQ-030 In DRAIN, mem_resp_valid SHALL discard the response and move the FSM to FETCH, with no push.
REQ-031 The buffer SHALL never overflow (guaranteed by REQ-017) and SHALL never underflow (a pop requires instr_valid).

Reset
REQ-032 While reset is 1: fetch PC=RESET_PC, FSM=FETCH, buffer count=0, mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
REQ-033 Assertion of reset mid-operation SHALL abandon any outstanding request; a response arriving after reset deasserts is ignored by REQ-022.
REQ-034 The first request SHALL be presented in the first cycle after reset deasserts, with mem_req_addr=RESET_PC.

Verification
REQ-035 Single-cycle memory (ready=1, response 1 cycle later, word=addr+100), instr_ready=1 -> decode sees pc 0,4,8 with data 100,104,108, one instruction every 2 cycles.
REQ-036 instr_ready=0 for 10 cycles -> exactly 2 entries buffered (pc 0, 4), mem_req_valid stays 0, and nothing is lost when instr_ready rises.
REQ-037 mem_req_ready=0 for 3 cycles -> mem_req_addr is held at 0 and the PC does not advance.
REQ-038 redirect_pc=32'h0000_0043 while in WAIT with the response 2 cycles late -> DRAIN, the late word is dropped, the next request address is 32'h40, and the buffer is empty.
REQ-039 Redirect with mem_resp_valid and instr_ready in the same cycle -> no push, no pop, buffer empty, next instr_pc=redirect target.
REQ-040 RESET_PC=32'hFFFF_FFFC -> instr_pc sequence FFFF_FFFC, 0000_0000; async reset pulse mid-WAIT -> outputs clear immediately, with no clock edge required.
